// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array result path.
//   DEF_MATRIX_SIZE : default array dimension N (rows = cols = N)
//   DEF_DATA_SIZE   : default width of one partial-sum element
//   state_t         : result_collector FSM states
package systolic_pkg;

    localparam int DEF_MATRIX_SIZE = 2;
    localparam int DEF_DATA_SIZE   = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Width of a row index; kept at least 1 so N=1 still gets a real signal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/column_buffer.sv
// Storage for one output column of the array: N result words written in
// arrival order, a write counter and the derived full status.
//   clk, reset   : clock, synchronous active-low reset (counter only)
//   clear        : restart the column (counter back to 0)
//   wr_en        : column result present this cycle
//   wr_data      : column result word
//   rd_idx       : row to present on rd_data
//   rd_data      : stored word for row rd_idx
//   full_next    : column will be full after this edge
//   wr_ovf       : write attempted while already full (data discarded)
module column_buffer #(
    parameter int N  = 2,
    parameter int W  = 32,
    parameter int IW = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic [IW-1:0] rd_idx,
    output logic [W-1:0]  rd_data,
    output logic          full_next,
    output logic          wr_ovf
);

    localparam int CW = $clog2(N) + 1;

    logic [W-1:0]  mem [N];
    logic [CW-1:0] cnt;
    logic          full;
    logic          wr_ok;

    assign full      = (cnt == CW'(N));
    assign wr_ok     = wr_en & ~full;
    assign wr_ovf    = wr_en & full;
    // Look-ahead so the filling write and the state change share one edge.
    assign full_next = full | (wr_ok & (cnt == CW'(N - 1)));
    assign rd_data   = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (wr_ok)
            cnt <= cnt + CW'(1);
    end

    // Payload storage carries no reset.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[cnt[IW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/result_collector.sv
// Collects the skewed bottom-row outputs of an N x N systolic array and
// replays them as deskewed rows over a valid/ready stream.
//   clk, reset : clock, synchronous active-low reset
//   start      : arm collection of one N x N result (IDLE / DONE only)
//   col_valid  : per-column result present
//   col_data   : column results, column j at [j*DATA_SIZE +: DATA_SIZE]
//   out_valid  : out_row holds a valid row
//   out_ready  : downstream accepts the row
//   out_row    : deskewed row, same packing as col_data (0 when idle)
//   done       : all N rows accepted
//   overflow   : sticky, a column received more than N results
module result_collector
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
    parameter int DATA_SIZE   = DEF_DATA_SIZE
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [MATRIX_SIZE-1:0]          col_valid,
    input  logic [MATRIX_SIZE*DATA_SIZE-1:0] col_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [MATRIX_SIZE*DATA_SIZE-1:0] out_row,
    output logic                            done,
    output logic                            overflow
);

    localparam int IW = idx_w(MATRIX_SIZE);

    state_t                                    state;
    logic [IW-1:0]                             rd_ptr;
    logic [MATRIX_SIZE-1:0]                    col_full_next;
    logic [MATRIX_SIZE-1:0]                    col_ovf;
    logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]     col_rd;
    logic                                      accept_start;
    logic                                      collecting;
    logic                                      hs;
    logic                                      last_row;

    assign accept_start = start & ((state == IDLE) | (state == DONE));
    assign collecting   = (state == COLLECT);
    assign hs           = out_valid & out_ready;
    assign last_row     = (rd_ptr == IW'(MATRIX_SIZE - 1));

    for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
        column_buffer #(
            .N  (MATRIX_SIZE),
            .W  (DATA_SIZE),
            .IW (IW)
        ) u_col (
            .clk       (clk),
            .reset     (reset),
            .clear     (accept_start),
            .wr_en     (collecting & col_valid[j]),
            .wr_data   (col_data[j*DATA_SIZE +: DATA_SIZE]),
            .rd_idx    (rd_ptr),
            .rd_data   (col_rd[j]),
            .full_next (col_full_next[j]),
            .wr_ovf    (col_ovf[j])
        );
    end

    // Buffers are frozen outside COLLECT, so the row is stable under backpressure.
    assign out_row = out_valid ? col_rd : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= COLLECT;
                        overflow <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (|col_ovf)
                        overflow <= 1'b1;
                    if (&col_full_next) begin
                        state     <= DRAIN;
                        out_valid <= 1'b1;
                        rd_ptr    <= '0;
                    end
                end
                DRAIN: begin
                    if (hs) begin
                        if (last_row) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            rd_ptr <= rd_ptr + IW'(1);
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state    <= COLLECT;
                        done     <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
